// File: rtl/nic.sv
// Ring NIC: one-packet in/out buffers behind four memory-mapped registers,
// with a valid/ready router handshake and a polarity-gated send path.
module nic #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [0:1]            addr,
  input  logic [0:DATA_WIDTH-1] d_in,
  output logic [0:DATA_WIDTH-1] d_out,
  input  logic                  nicEn,
  input  logic                  nicWrEn,
  output logic                  net_so,
  input  logic                  net_ro,
  output logic [0:DATA_WIDTH-1] net_do,
  input  logic                  net_polarity,
  input  logic                  net_si,
  output logic                  net_ri,
  input  logic [0:DATA_WIDTH-1] net_di
);

  logic [0:DATA_WIDTH-1] in_buf_q, in_buf_d;
  logic [0:DATA_WIDTH-1] out_buf_q, out_buf_d;
  logic                  in_full_q, in_full_d;
  logic                  out_full_q, out_full_d;

  logic rd_en, wr_en;
  logic sel_ib, sel_is, sel_ob, sel_os;

  assign rd_en  = nicEn & ~nicWrEn;
  assign wr_en  = nicEn & nicWrEn;
  assign sel_ib = (addr == 2'b00);
  assign sel_is = (addr == 2'b01);
  assign sel_ob = (addr == 2'b10);
  assign sel_os = (addr == 2'b11);

  assign net_ri = ~in_full_q & ~reset;
  // out_buf[0] is the VC bit; send only on the opposite ring phase
  assign net_so = out_full_q & net_ro &
                  (out_buf_q[0] != net_polarity) & ~reset;
  assign net_do = out_buf_q;

  always_comb begin
    in_buf_d   = in_buf_q;
    in_full_d  = in_full_q;
    out_buf_d  = out_buf_q;
    out_full_d = out_full_q;
    if (net_si && net_ri) begin
      in_buf_d  = net_di;
      in_full_d = 1'b1;
    end else if (rd_en && sel_ib) begin
      in_full_d = 1'b0;
    end
    if (net_so) begin
      out_full_d = 1'b0;
    end else if (wr_en && sel_ob && !out_full_q) begin
      out_buf_d  = d_in;
      out_full_d = 1'b1;
    end
  end

  always_comb begin
    d_out = '0;
    if (rd_en) begin
      unique case (1'b1)
        sel_ib: d_out = in_buf_q;
        sel_is: d_out[DATA_WIDTH-1] = in_full_q;
        sel_ob: d_out = out_buf_q;
        sel_os: d_out[DATA_WIDTH-1] = out_full_q;
        default: d_out = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_buf_q   <= '0;
      in_full_q  <= 1'b0;
      out_buf_q  <= '0;
      out_full_q <= 1'b0;
    end else begin
      in_buf_q   <= in_buf_d;
      in_full_q  <= in_full_d;
      out_buf_q  <= out_buf_d;
      out_full_q <= out_full_d;
    end
  end

endmodule

// File: tb/tb_nic.sv
// Directed testbench for nic: reset, receive, polarity send,
// back-pressure, full input and mid-operation reset.
module tb_nic;

  logic        clk = 1'b0;
  logic        reset;
  logic [0:1]  addr;
  logic [0:63] d_in;
  logic [0:63] d_out;
  logic        nicEn;
  logic        nicWrEn;
  logic        net_so;
  logic        net_ro;
  logic [0:63] net_do;
  logic        net_polarity;
  logic        net_si;
  logic        net_ri;
  logic [0:63] net_di;

  int errors = 0;
  int checks = 0;

  nic #(.DATA_WIDTH(64)) dut (
    .clk(clk), .reset(reset), .addr(addr), .d_in(d_in),
    .d_out(d_out), .nicEn(nicEn), .nicWrEn(nicWrEn),
    .net_so(net_so), .net_ro(net_ro), .net_do(net_do),
    .net_polarity(net_polarity), .net_si(net_si),
    .net_ri(net_ri), .net_di(net_di)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [0:1] a);
    nicEn = 1'b1; nicWrEn = 1'b0; addr = a;
    #1;
  endtask

  task automatic wr(input logic [0:1] a, input logic [0:63] v);
    nicEn = 1'b1; nicWrEn = 1'b1; addr = a; d_in = v;
    #1;
  endtask

  task automatic nop();
    nicEn = 1'b0; nicWrEn = 1'b0; addr = 2'b00; d_in = '0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; net_si = 1'b1; net_ro = 1'b1;
    net_di = 64'hFFFF_0000_FFFF_0000;
    step(); step();
    checks++;
    if (net_ri !== 1'b0) begin
      errors++; $display("FAIL rst_ri got=%b exp=0", net_ri);
    end
    checks++;
    if (net_so !== 1'b0) begin
      errors++; $display("FAIL rst_so got=%b exp=0", net_so);
    end
    checks++;
    if (net_do !== 64'h0) begin
      errors++; $display("FAIL rst_do got=%h exp=0", net_do);
    end
    for (int a = 0; a < 4; a++) begin
      rd(2'(a));
      checks++;
      if (d_out !== 64'h0) begin
        errors++; $display("FAIL rst_rd%0d got=%h exp=0", a, d_out);
      end
    end
    nop();
    reset = 1'b0; net_si = 1'b0; net_ro = 1'b0;
    #1;
    checks++;
    if (net_ri !== 1'b1) begin
      errors++; $display("FAIL rst_release_ri got=%b exp=1", net_ri);
    end
  endtask

  task automatic test_receive();
    net_si = 1'b1; net_di = 64'hDEAD_BEEF_0000_0001;
    step();
    net_si = 1'b0; net_di = '0;
    #1;
    checks++;
    if (net_ri !== 1'b0) begin
      errors++; $display("FAIL rx_ri got=%b exp=0", net_ri);
    end
    rd(2'b01);
    checks++;
    if (d_out !== 64'h1) begin
      errors++; $display("FAIL rx_stat got=%h exp=1", d_out);
    end
    rd(2'b00);
    checks++;
    if (d_out !== 64'hDEAD_BEEF_0000_0001) begin
      errors++;
      $display("FAIL rx_data got=%h exp=deadbeef00000001", d_out);
    end
    step();
    nop();
    checks++;
    if (net_ri !== 1'b1) begin
      errors++; $display("FAIL rx_ri_after got=%b exp=1", net_ri);
    end
    rd(2'b01);
    checks++;
    if (d_out !== 64'h0) begin
      errors++; $display("FAIL rx_stat_after got=%h exp=0", d_out);
    end
    nop();
  endtask

  task automatic test_send_polarity();
    net_ro = 1'b1; net_polarity = 1'b0;
    wr(2'b10, 64'h8000_0000_0000_00AA);
    checks++;
    if (d_out !== 64'h0) begin
      errors++; $display("FAIL tx_wr_dout got=%h exp=0", d_out);
    end
    step();
    nop();
    net_polarity = 1'b1;
    rd(2'b11);
    checks++;
    if (net_so !== 1'b0) begin
      errors++; $display("FAIL tx_so_pol1 got=%b exp=0", net_so);
    end
    checks++;
    if (d_out !== 64'h1) begin
      errors++; $display("FAIL tx_stat_before got=%h exp=1", d_out);
    end
    nop();
    step();
    net_polarity = 1'b0;
    #1;
    checks++;
    if (net_so !== 1'b1) begin
      errors++; $display("FAIL tx_so_pol0 got=%b exp=1", net_so);
    end
    checks++;
    if (net_do !== 64'h8000_0000_0000_00AA) begin
      errors++;
      $display("FAIL tx_do got=%h exp=80000000000000aa", net_do);
    end
    step();
    net_polarity = 1'b1;
    rd(2'b11);
    checks++;
    if (d_out !== 64'h0) begin
      errors++; $display("FAIL tx_stat_after got=%h exp=0", d_out);
    end
    checks++;
    if (net_so !== 1'b0) begin
      errors++; $display("FAIL tx_so_after got=%b exp=0", net_so);
    end
    nop();
    net_ro = 1'b0;
  endtask

  task automatic test_back_pressure();
    net_ro = 1'b0;
    wr(2'b10, 64'h0000_0000_0000_0123);
    step();
    for (int i = 0; i < 5; i++) begin
      net_polarity = ~net_polarity;
      if (i == 2) wr(2'b10, 64'h5);
      else rd(2'b11);
      checks++;
      if (net_so !== 1'b0) begin
        errors++; $display("FAIL bp_so%0d got=%b exp=0", i, net_so);
      end
      if (i != 2) begin
        checks++;
        if (d_out !== 64'h1) begin
          errors++; $display("FAIL bp_stat%0d got=%h exp=1", i, d_out);
        end
      end
      step();
    end
    rd(2'b10);
    checks++;
    if (d_out !== 64'h123) begin
      errors++; $display("FAIL bp_keep got=%h exp=123", d_out);
    end
    nop();
    net_ro = 1'b1; net_polarity = 1'b0;
    #1;
    checks++;
    if (net_so !== 1'b0) begin
      errors++; $display("FAIL bp_so_samepol got=%b exp=0", net_so);
    end
    step();
    net_polarity = 1'b1;
    #1;
    checks++;
    if (net_so !== 1'b1 || net_do !== 64'h123) begin
      errors++;
      $display("FAIL bp_send got so=%b do=%h exp so=1 do=123",
               net_so, net_do);
    end
    step();
    rd(2'b11);
    checks++;
    if (d_out !== 64'h0) begin
      errors++; $display("FAIL bp_stat_after got=%h exp=0", d_out);
    end
    nop();
    net_ro = 1'b0;
  endtask

  task automatic test_full_input();
    net_si = 1'b1; net_di = 64'h0000_0000_0000_00A1;
    step();
    net_di = 64'h0000_0000_0000_00B2;
    step(); step();
    checks++;
    if (net_ri !== 1'b0) begin
      errors++; $display("FAIL full_ri got=%b exp=0", net_ri);
    end
    rd(2'b00);
    checks++;
    if (d_out !== 64'hA1) begin
      errors++; $display("FAIL full_keep got=%h exp=a1", d_out);
    end
    step();
    nop();
    checks++;
    if (net_ri !== 1'b1) begin
      errors++; $display("FAIL full_ri_reopen got=%b exp=1", net_ri);
    end
    step();
    net_si = 1'b0;
    #1;
    checks++;
    if (net_ri !== 1'b0) begin
      errors++; $display("FAIL full_ri_recap got=%b exp=0", net_ri);
    end
    rd(2'b00);
    checks++;
    if (d_out !== 64'hB2) begin
      errors++; $display("FAIL full_newpkt got=%h exp=b2", d_out);
    end
    step();
    nop();
  endtask

  task automatic test_mid_reset();
    net_ro = 1'b0; net_polarity = 1'b1;
    net_si = 1'b1; net_di = 64'h99;
    wr(2'b10, 64'h77);
    step();
    net_si = 1'b0;
    rd(2'b01);
    checks++;
    if (d_out !== 64'h1) begin
      errors++; $display("FAIL mr_in_pre got=%h exp=1", d_out);
    end
    rd(2'b11);
    checks++;
    if (d_out !== 64'h1) begin
      errors++; $display("FAIL mr_out_pre got=%h exp=1", d_out);
    end
    nop();
    reset = 1'b1;
    step();
    reset = 1'b0; net_ro = 1'b1;
    #1;
    checks++;
    if (net_so !== 1'b0) begin
      errors++; $display("FAIL mr_so_p1 got=%b exp=0", net_so);
    end
    net_polarity = 1'b0;
    #1;
    checks++;
    if (net_so !== 1'b0) begin
      errors++; $display("FAIL mr_so_p0 got=%b exp=0", net_so);
    end
    rd(2'b01);
    checks++;
    if (d_out !== 64'h0) begin
      errors++; $display("FAIL mr_in_post got=%h exp=0", d_out);
    end
    rd(2'b11);
    checks++;
    if (d_out !== 64'h0) begin
      errors++; $display("FAIL mr_out_post got=%h exp=0", d_out);
    end
    checks++;
    if (net_ri !== 1'b1 || net_do !== 64'h0) begin
      errors++;
      $display("FAIL mr_ri_do got ri=%b do=%h exp ri=1 do=0",
               net_ri, net_do);
    end
    nop();
    net_ro = 1'b0;
  endtask

  initial begin
    reset = 1'b1; addr = 2'b00; d_in = '0;
    nicEn = 1'b0; nicWrEn = 1'b0;
    net_ro = 1'b0; net_polarity = 1'b0;
    net_si = 1'b0; net_di = '0;
    test_reset();
    test_receive();
    test_send_polarity();
    test_back_pressure();
    test_full_input();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
